// File: rtl/uio_port_ctrl.sv
// Bidirectional pin controller for the uio_* group: direction/output latches,
// input synchronisers, per-channel edge counters and a valid/ready command port.
module uio_port_ctrl #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             edge_irq,
    input  logic [WIDTH-1:0] uio_in,
    output logic [WIDTH-1:0] uio_out,
    output logic [WIDTH-1:0] uio_oe
);

    localparam int          CH_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [31:0] WIDTH_U = WIDTH;

    localparam logic [1:0] OP_OE   = 2'b00;
    localparam logic [1:0] OP_OUT  = 2'b01;
    localparam logic [1:0] OP_READ = 2'b10;
    localparam logic [1:0] OP_MODE = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RDPEND = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] dly_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] oe_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] sel_q;
    logic             irq_q, irq_d;
    logic [CNT_W-1:0] rd_data_q;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    logic             accept;
    logic [WIDTH-1:0] hit;
    logic [31:0]      idx_full;
    logic             ch_ok;
    logic [CNT_W-1:0] rd_val;
    logic [WIDTH-1:0] sync_last;

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign accept    = ena & cmd_valid & (state_q == ST_IDLE);

    // The whole operand is the index, so any upper bit set means out of range.
    assign idx_full = 32'(cmd_data);
    assign ch_ok    = (idx_full < WIDTH_U);
    assign rd_val   = ch_ok ? cnt_q[cmd_data[CH_W-1:0]] : '0;

    assign hit = ((sel_q & rise_q) | (~sel_q & fall_q)) & ~oe_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept && (cmd_op == OP_READ)) state_d = ST_RDPEND;
            ST_RDPEND: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Saturating counters; a mode write clears everything and beats a same-cycle edge.
    always_comb begin
        irq_d = irq_q | (|hit);
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (hit[i] && (cnt_q[i] != {CNT_W{1'b1}})) cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
        if (accept && (cmd_op == OP_MODE)) begin
            irq_d = 1'b0;
            for (int i = 0; i < WIDTH; i++) cnt_d[i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            dly_q     <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            oe_q      <= '0;
            out_q     <= '0;
            sel_q     <= '1;
            irq_q     <= 1'b0;
            rd_data_q <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else if (ena) begin
            state_q   <= state_d;
            sync_q[0] <= uio_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            dly_q     <= sync_last;
            rise_q    <= sync_last & ~dly_q;
            fall_q    <= ~sync_last & dly_q;
            irq_q     <= irq_d;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
            if (accept) begin
                case (cmd_op)
                    OP_OE:   oe_q      <= cmd_data;
                    OP_OUT:  out_q     <= cmd_data;
                    OP_READ: rd_data_q <= rd_val;
                    OP_MODE: sel_q     <= cmd_data;
                    default: ;
                endcase
            end
        end
    end

    assign cmd_ready = ena & (state_q == ST_IDLE);
    assign rd_valid  = (state_q == ST_RDPEND);
    assign rd_data   = rd_data_q;
    assign edge_irq  = irq_q;
    assign uio_out   = out_q;
    assign uio_oe    = oe_q;

endmodule

// File: tb/tb_uio_port_ctrl.sv
// Directed and randomized bench for uio_port_ctrl with a cycle-level reference model.
module tb_uio_port_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic [3:0] rd_data;
    logic       rd_valid;
    logic       edge_irq;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int tests = 0;
    int fails = 0;

    uio_port_ctrl #(.WIDTH(8), .SYNC_STAGES(2), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rd_data(rd_data), .rd_valid(rd_valid), .edge_irq(edge_irq),
        .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    // Reference state; h[k] is the pad value sampled k+1 enabled edges ago.
    logic [7:0] m_oe = 8'h00, m_out = 8'h00, m_sel = 8'hFF;
    int         m_cnt [8];
    logic       m_irq = 1'b0, m_rdv = 1'b0;
    logic [3:0] m_rdd = 4'h0;
    logic [7:0] h [4];

    task automatic model_step();
        logic [7:0] nw, od, hit;
        logic acc, nrdv;
        if (rst) begin
            m_oe = 8'h00; m_out = 8'h00; m_sel = 8'hFF; m_irq = 1'b0; m_rdv = 1'b0; m_rdd = 4'h0;
            for (int i = 0; i < 8; i++) m_cnt[i] = 0;
            for (int i = 0; i < 4; i++) h[i] = 8'h00;
        end else if (ena) begin
            // An edge sampled at edge n is counted at edge n+3.
            nw = h[2];
            od = h[3];
            hit = ((m_sel & nw & ~od) | (~m_sel & ~nw & od)) & ~m_oe;
            acc = cmd_valid && !m_rdv;
            nrdv = acc && (cmd_op == 2'b10);
            if (nrdv) m_rdd = (cmd_data < 8) ? 4'(m_cnt[cmd_data[2:0]]) : 4'h0;
            for (int i = 0; i < 8; i++) begin
                if (hit[i]) begin
                    if (m_cnt[i] < 15) m_cnt[i] = m_cnt[i] + 1;
                    m_irq = 1'b1;
                end
            end
            if (acc) begin
                case (cmd_op)
                    2'b00: m_oe = cmd_data;
                    2'b01: m_out = cmd_data;
                    2'b11: begin
                        m_sel = cmd_data;
                        m_irq = 1'b0;
                        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
                    end
                    default: ;
                endcase
            end
            h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = uio_in;
            m_rdv = nrdv;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("uio_oe", 32'(uio_oe), 32'(m_oe));
        chk("uio_out", 32'(uio_out), 32'(m_out));
        chk("rd_valid", 32'(rd_valid), 32'(m_rdv));
        chk("rd_data", 32'(rd_data), 32'(m_rdd));
        chk("edge_irq", 32'(edge_irq), 32'(m_irq));
        chk("cmd_ready", 32'(cmd_ready), 32'(ena && !m_rdv));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic cmd(input logic [1:0] op, input logic [7:0] data);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic rd(input logic [7:0] ch, input logic [31:0] exp, input string tag);
        cmd(2'b10, ch);
        chk(tag, 32'(rd_data), exp);
        chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
        tick();
        chk({tag, "_pulse_end"}, 32'(rd_valid), 32'd0);
    endtask

    task automatic pulse(input int b, input int n);
        repeat (n) begin
            uio_in[b] = 1'b1; tick(); tick();
            uio_in[b] = 1'b0; tick(); tick();
        end
    endtask

    initial begin
        logic [7:0] s_oe, s_out;
        logic [3:0] s_rdd;
        logic       s_irq;
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
        for (int i = 0; i < 4; i++) h[i] = 8'h00;

        tick(); tick();
        chk("rst_oe", 32'(uio_oe), 32'h0);
        chk("rst_ready", 32'(cmd_ready), 32'h1);
        rst = 1'b0;
        tick();

        cmd(2'b00, 8'hF0);
        chk("op00_oe", 32'(uio_oe), 32'hF0);
        chk("op00_out", 32'(uio_out), 32'h00);
        chk("op00_ready", 32'(cmd_ready), 32'h1);

        // First rise on ch2: edge_irq appears at the third edge after the sampling edge.
        uio_in[2] = 1'b1;
        tick(); tick(); tick();
        chk("irq_early", 32'(edge_irq), 32'h0);
        tick();
        chk("irq_latency", 32'(edge_irq), 32'h1);
        uio_in[2] = 1'b0; tick(); tick();
        pulse(2, 2);
        repeat (5) tick();
        rd(8'd2, 32'd3, "rise_cnt_ch2");

        cmd(2'b11, 8'h00);
        chk("mode_clr_irq", 32'(edge_irq), 32'h0);
        pulse(0, 5);
        repeat (5) tick();
        rd(8'd0, 32'd5, "fall_cnt_ch0");

        cmd(2'b11, 8'hFF);
        pulse(1, 20);
        repeat (5) tick();
        rd(8'd1, 32'd15, "sat_cnt_ch1");
        chk("sat_irq", 32'(edge_irq), 32'h1);

        uio_in[3] = 1'b1;
        tick(); tick(); tick();
        cmd(2'b11, 8'hFF);
        chk("clr_wins_irq", 32'(edge_irq), 32'h0);
        repeat (4) tick();
        rd(8'd3, 32'd0, "clr_wins_cnt");
        uio_in[3] = 1'b0;
        repeat (5) tick();

        rd(8'd9, 32'd0, "oob_read");

        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_data = 8'd1;
        tick();
        cmd_op = 2'b00; cmd_data = 8'hAA;
        chk("pend_ready", 32'(cmd_ready), 32'h0);
        tick();
        cmd_valid = 1'b0;
        chk("pend_ignored", 32'(uio_oe), 32'hF0);

        for (int n = 0; n < 400; n++) begin
            uio_in = uio_in ^ 8'($urandom & $urandom);
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_op = 2'($urandom);
            cmd_data = 8'($urandom);
            if (cmd_op == 2'b00) cmd_data = cmd_data & 8'h0F;
            if (cmd_op == 2'b10) cmd_data = 8'($urandom_range(0, 11));
            tick();
        end
        cmd_valid = 1'b0;
        repeat (3) tick();

        s_oe = uio_oe; s_out = uio_out; s_rdd = rd_data; s_irq = edge_irq;
        ena = 1'b0;
        #1;
        chk("dis_ready", 32'(cmd_ready), 32'h0);
        for (int n = 0; n < 8; n++) begin
            uio_in = 8'($urandom);
            cmd_valid = 1'b1; cmd_op = 2'($urandom); cmd_data = 8'($urandom);
            tick();
        end
        cmd_valid = 1'b0;
        chk("dis_oe", 32'(uio_oe), 32'(s_oe));
        chk("dis_out", 32'(uio_out), 32'(s_out));
        chk("dis_rdd", 32'(rd_data), 32'(s_rdd));
        chk("dis_irq", 32'(edge_irq), 32'(s_irq));
        ena = 1'b1;
        repeat (8) tick();

        cmd(2'b00, 8'h5A);
        cmd(2'b01, 8'hC3);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_data = 8'd4;
        rst = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("rst_rdv", 32'(rd_valid), 32'h0);
        chk("rst2_oe", 32'(uio_oe), 32'h0);
        chk("rst2_out", 32'(uio_out), 32'h0);
        chk("rst2_rdd", 32'(rd_data), 32'h0);
        chk("rst2_irq", 32'(edge_irq), 32'h0);
        chk("rst2_ready", 32'(cmd_ready), 32'h1);
        rst = 1'b0;
        uio_in = 8'h00;
        repeat (6) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
